// File: rtl/rr_grant_arbiter_pkg.sv
// Shared definitions for the round-robin grant arbiter: requester count,
// owner id width and the two-state FSM encoding.
package rr_grant_arbiter_pkg;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    // Rotate right so that bit 0 of the result is req[ptr].
    function automatic logic [NUM_REQ-1:0] rotate_req(input logic [NUM_REQ-1:0] req,
                                                      input logic [ID_W-1:0]    ptr);
        logic [NUM_REQ-1:0] rot;
        case (ptr)
            2'd0:    rot = req;
            2'd1:    rot = {req[0],   req[3:1]};
            2'd2:    rot = {req[1:0], req[3:2]};
            2'd3:    rot = {req[2:0], req[3]};
            default: rot = req;
        endcase
        return rot;
    endfunction

endpackage

// File: rtl/rr_grant_arbiter_chk.sv
// Protocol checker for rr_grant_arbiter outputs, bound in by the environment.
module rr_grant_arbiter_chk
    import rr_grant_arbiter_pkg::*;
(
    input logic               clk,
    input logic               rst_n,
    input logic [NUM_REQ-1:0] gnt,
    input logic               busy,
    input logic               timeout
);

    a_gnt_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
    a_gnt_iff_busy: assert property (@(posedge clk) disable iff (!rst_n) ((gnt != 4'b0000) == busy));
    a_timeout_idle: assert property (@(posedge clk) disable iff (!rst_n) (timeout |-> !busy));

endmodule

// File: rtl/rr_grant_arbiter_dec2to4.sv
// Enabled 2-to-4 decoder: one-hot of a when e is high, all zero otherwise.
module dec2to4_en
    import rr_grant_arbiter_pkg::*;
(
    input  logic [ID_W-1:0]    a,
    input  logic               e,
    output logic [NUM_REQ-1:0] y
);

    // One-hot decode gated by enable
    always_comb begin
        y = 4'b0000;
        if (e) begin
            y = 4'b0001 << a;
        end else begin
            y = 4'b0000;
        end
    end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Four-requester round-robin arbiter; holds a grant until done, request drop
// or hold timeout, with at least one idle cycle between owners.
module rr_grant_arbiter
    import rr_grant_arbiter_pkg::*;
#(
    parameter int HOLD_MAX = 16,
    parameter int HOLD_W   = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_id,
    output logic               busy,
    output logic               timeout
);

    localparam logic [HOLD_W-1:0] HOLD_LAST = (HOLD_MAX == 0) ? HOLD_W'(0) : HOLD_W'(HOLD_MAX - 1);

    arb_state_e          state_q, state_d;
    logic [ID_W-1:0]     gnt_id_q, gnt_id_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic                busy_q, busy_d;
    logic                timeout_q, timeout_d;

    logic [NUM_REQ-1:0]  rot_s;
    logic [ID_W-1:0]     off_s;
    logic [ID_W-1:0]     winner_s;
    logic                rel_done_s, rel_drop_s, rel_to_s;

    // Wrap-around priority search: rotate by ptr, find first, un-rotate
    always_comb begin
        rot_s = rotate_req(req, ptr_q);
        casez (rot_s)
            4'b???1: off_s = 2'd0;
            4'b??10: off_s = 2'd1;
            4'b?100: off_s = 2'd2;
            4'b1000: off_s = 2'd3;
            default: off_s = 2'd0;
        endcase
        winner_s = ptr_q + off_s;
    end

    // Release conditions of the current grant
    always_comb begin
        rel_done_s = done;
        rel_drop_s = !req[gnt_id_q];
        rel_to_s   = (HOLD_MAX != 0) && (hold_cnt_q == HOLD_LAST);
    end

    // Next-state logic for the FSM, pointer, hold counter and timeout pulse
    always_comb begin
        state_d    = state_q;
        gnt_id_d   = gnt_id_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        busy_d     = busy_q;
        timeout_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en && (req != 4'b0000)) begin
                    gnt_id_d   = winner_s;
                    busy_d     = 1'b1;
                    hold_cnt_d = HOLD_W'(0);
                    state_d    = ST_GRANT;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (rel_done_s || rel_drop_s || rel_to_s) begin
                    busy_d    = 1'b0;
                    ptr_d     = gnt_id_q + 2'd1;
                    state_d   = ST_IDLE;
                    // Only a pure timeout release is flagged
                    timeout_d = rel_to_s && !rel_done_s && !rel_drop_s;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            gnt_id_q   <= 2'd0;
            ptr_q      <= 2'd0;
            hold_cnt_q <= HOLD_W'(0);
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_id_q   <= gnt_id_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            busy_q     <= busy_d;
            timeout_q  <= timeout_d;
        end
    end

    dec2to4_en u_dec (
        .a (gnt_id_q),
        .e (busy_q),
        .y (gnt)
    );

    assign gnt_id  = gnt_id_q;
    assign busy    = busy_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Self-checking bench for rr_grant_arbiter: directed scenarios plus random
// traffic, compared against a cycle-level behavioural model.
module tb_rr_grant_arbiter;

    localparam int HM = 4;
    localparam int HW = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    // Behavioural model: owner index, rotating start point, cycles held so far
    bit m_busy;
    int m_owner;
    int m_ptr;
    int m_held;
    bit m_to;

    rr_grant_arbiter #(.HOLD_MAX(HM), .HOLD_W(HW)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req), .done(done),
        .gnt(gnt), .gnt_id(gnt_id), .busy(busy), .timeout(timeout)
    );

    rr_grant_arbiter_chk u_chk (
        .clk(clk), .rst_n(rst_n), .gnt(gnt), .busy(busy), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy  = 1'b0;
        m_owner = 0;
        m_ptr   = 0;
        m_held  = 0;
        m_to    = 1'b0;
    endtask

    // One clock edge of the model, using the inputs held across that edge
    task automatic model_edge();
        bit rel_d, rel_r, rel_t;
        m_to = 1'b0;
        if (!m_busy) begin
            if (en && req != 4'b0000) begin
                for (int i = 0; i < 4; i++) begin
                    if (!m_busy && req[(m_ptr + i) % 4]) begin
                        m_owner = (m_ptr + i) % 4;
                        m_busy  = 1'b1;
                    end
                end
                m_held = 1;
            end
        end else begin
            rel_d = done;
            rel_r = !req[m_owner];
            rel_t = (HM != 0) && (m_held == HM);
            if (rel_d || rel_r || rel_t) begin
                m_busy = 1'b0;
                m_ptr  = (m_owner + 1) % 4;
                m_to   = rel_t && !rel_d && !rel_r;
            end else begin
                m_held++;
            end
        end
    endtask

    task automatic compare_all();
        logic [3:0] exp_gnt;
        exp_gnt = m_busy ? (4'b0001 << m_owner) : 4'b0000;
        check_eq("gnt", gnt, exp_gnt);
        check_eq("busy", busy, m_busy);
        check_eq("timeout", timeout, m_to);
        if (m_busy) check_eq("gnt_id", gnt_id, m_owner);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
        done = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = 4'b0000;
        done  = 1'b0;
        #1;
        model_reset();
        compare_all();
        check_eq("rst_gnt_id", gnt_id, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_grant(input string tag);
        for (int w = 0; w < 4 && !busy; w++) step();
        check_eq(tag, busy, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; req = 4'b0000; done = 1'b0;
        model_reset();
        do_reset();

        // Basic grant and release
        en = 1'b1; req = 4'b0100;
        step();
        check_eq("t1_gnt", gnt, 4'b0100);
        check_eq("t1_id", gnt_id, 2'd2);
        done = 1'b1;
        step();
        check_eq("t1_rel", gnt, 4'b0000);
        req = 4'b0000;
        step();

        // Fairness with all requesting
        do_reset();
        en = 1'b1; req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_grant("fair_wait");
            check_eq("fair_order", gnt_id, k % 4);
            done = 1'b1;
            step();
            check_eq("fair_idle", gnt, 4'b0000);
        end

        // Hold timeout
        do_reset();
        en = 1'b1; req = 4'b0001;
        for (int c = 0; c < HM; c++) begin
            step();
            check_eq("t3_hold", gnt, 4'b0001);
        end
        step();
        check_eq("t3_gnt_off", gnt, 4'b0000);
        check_eq("t3_timeout", timeout, 1'b1);
        step();
        check_eq("t3_regrant", gnt, 4'b0001);
        check_eq("t3_to_clear", timeout, 1'b0);

        // done coinciding with the last hold cycle
        repeat (HM - 1) step();
        done = 1'b1;
        step();
        check_eq("t4_gnt_off", gnt, 4'b0000);
        check_eq("t4_no_to", timeout, 1'b0);
        step();
        check_eq("t4_regrant", gnt, 4'b0001);
        // owner drops its request
        req = 4'b0010;
        step();
        check_eq("t4_drop_rel", gnt, 4'b0000);
        step();
        check_eq("t4_next_id", gnt_id, 2'd1);
        req = 4'b0000;
        step();

        // Enable gating
        do_reset();
        en = 1'b0; req = 4'b0010;
        repeat (3) step();
        check_eq("t5_blocked", busy, 1'b0);
        en = 1'b1;
        step();
        check_eq("t5_grant", gnt, 4'b0010);
        en = 1'b0; req = 4'b0110;
        repeat (2) step();
        check_eq("t5_persist", gnt, 4'b0010);
        done = 1'b1;
        step();
        check_eq("t5_release", busy, 1'b0);

        // Asynchronous reset in the middle of a grant
        en = 1'b1; req = 4'b0100;
        step();
        check_eq("t6_pre", gnt, 4'b0100);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_eq("t6_async_gnt", gnt, 4'b0000);
        check_eq("t6_async_busy", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        req = 4'b1000;
        step();
        check_eq("t6_grant3", gnt, 4'b1000);
        done = 1'b1;
        step();

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            en  = ($urandom_range(0, 9) < 8);
            req = 4'($urandom_range(0, 15));
            if (m_busy && $urandom_range(0, 7) != 0) req[m_owner] = 1'b1;
            done = ($urandom_range(0, 7) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
